zero_cmp_arbiter: RTL and testbench

- Shares one registered IEEE-754 single-precision zero-classifier between NUM_REQ requesters, such as cell-current, pack-current and temperature-delta monitors in the battery management datapath.
- Round-robin arbitration with a valid/ready handshake on every request port and on the single response port.
- Each response carries the requester ID and the gt/lt/eq/unord classification of the accepted operand.

---
 rtl/zero_cmp_pkg.sv | 38 +++
 rtl/fp32_zero_classify.sv | 11 +
 rtl/zero_cmp_arbiter.sv | 126 ++++++++++++
 tb/tb_zero_cmp_arbiter.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/zero_cmp_pkg.sv
// Shared FP32 field constants, the classification result struct and the classifier function
// used by the zero-compare arbiter.
package zero_cmp_pkg;

    localparam int unsigned SIGN_BIT = 31;
    localparam int unsigned EXP_MSB  = 30;
    localparam int unsigned EXP_LSB  = 23;
    localparam int unsigned MAN_W    = 23;
    localparam logic [7:0]  EXP_ALL1 = 8'hFF;

    typedef struct packed {
        logic gt;
        logic lt;
        logic eq;
        logic unord;
    } zc_result_t;

    // Exactly one flag is set; denormals and infinities count as nonzero.
    function automatic zc_result_t classify_fp32(input logic [31:0] x);
        zc_result_t       r;
        logic [7:0]       e;
        logic [MAN_W-1:0] m;
        r = '0;
        e = x[EXP_MSB:EXP_LSB];
        m = x[MAN_W-1:0];
        if (e == 8'h00 && m == '0) begin
            r.eq = 1'b1;
        end else if (e == EXP_ALL1 && m != '0) begin
            r.unord = 1'b1;
        end else if (x[SIGN_BIT]) begin
            r.lt = 1'b1;
        end else begin
            r.gt = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fp32_zero_classify.sv
// Combinational sign/zero/NaN classifier for one IEEE-754 single-precision operand.
module fp32_zero_classify
    import zero_cmp_pkg::*;
(
    input  logic [31:0] operand_i,
    output zc_result_t  result_c
);

    assign result_c = classify_fp32(operand_i);

endmodule

// File: rtl/zero_cmp_arbiter.sv
// Round-robin arbiter sharing one registered FP32 zero-classifier between NUM_REQ requesters,
// with valid/ready on every request port and on the response port.
module zero_cmp_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [32*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [ID_W-1:0]         rsp_id,
    output logic                    rsp_gt,
    output logic                    rsp_lt,
    output logic                    rsp_eq,
    output logic                    rsp_unord,
    output logic [15:0]             busy_cnt
);
    import zero_cmp_pkg::*;

    localparam int unsigned CNT_W   = 16;
    localparam int unsigned SCAN_W  = ID_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
    zc_result_t        rsp_res_q, rsp_res_d;
    logic [CNT_W-1:0]  busy_q, busy_d;

    logic              can_accept;
    logic              accept;
    logic              gnt_found;
    logic [ID_W-1:0]   gnt_idx;
    logic [SCAN_W-1:0] scan_sum;
    logic [31:0]       sel_data;
    zc_result_t        sel_res;

    assign can_accept = !rsp_valid_q || rsp_ready;
    assign accept     = can_accept && gnt_found;

    // First valid requester at or above the pointer, wrapping; the sum never exceeds 2*NUM_REQ-2.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        scan_sum  = '0;
        for (int k = 0; k < int'(NUM_REQ); k++) begin
            scan_sum = {1'b0, ptr_q} + SCAN_W'(k);
            if (scan_sum >= SCAN_W'(NUM_REQ)) begin
                scan_sum = scan_sum - SCAN_W'(NUM_REQ);
            end
            if (!gnt_found && req_valid[scan_sum[ID_W-1:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = scan_sum[ID_W-1:0];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (gnt_idx == ID_W'(i)) begin
                sel_data = req_data[32*i +: 32];
            end
        end
    end

    fp32_zero_classify u_classify (
        .operand_i (sel_data),
        .result_c  (sel_res)
    );

    // Accept reloads the output register even while draining, so there is no bubble.
    always_comb begin
        ptr_d       = ptr_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_res_d   = rsp_res_q;
        busy_d      = busy_q;
        if (accept) begin
            rsp_valid_d = 1'b1;
            rsp_id_d    = gnt_idx;
            rsp_res_d   = sel_res;
            ptr_d       = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
        if (rsp_valid_q && !rsp_ready && busy_q != CNT_MAX) begin
            busy_d = busy_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_res_q   <= '0;
            busy_q      <= '0;
        end else begin
            ptr_q       <= ptr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_res_q   <= rsp_res_d;
            busy_q      <= busy_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_gt    = rsp_res_q.gt;
    assign rsp_lt    = rsp_res_q.lt;
    assign rsp_eq    = rsp_res_q.eq;
    assign rsp_unord = rsp_res_q.unord;
    assign busy_cnt  = busy_q;

endmodule

// File: tb/tb_zero_cmp_arbiter.sv
// Directed bench for zero_cmp_arbiter: a reference arbiter/classifier model pushes expected
// responses into a scoreboard that is compared whenever the DUT presents a response.
module tb_zero_cmp_arbiter;

    localparam int NR = 4;

    logic          clk;
    logic          rst_n;
    logic [NR-1:0] req_valid;
    logic [32*NR-1:0] req_data;
    logic [NR-1:0] req_ready;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [1:0]    rsp_id;
    logic          rsp_gt, rsp_lt, rsp_eq, rsp_unord;
    logic [15:0]   busy_cnt;

    zero_cmp_arbiter #(.NUM_REQ(NR), .ID_W(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_gt    (rsp_gt),
        .rsp_lt    (rsp_lt),
        .rsp_eq    (rsp_eq),
        .rsp_unord (rsp_unord),
        .busy_cnt  (busy_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] data_m [NR];
    logic [5:0]  sb_q [$];
    logic [1:0]  ptr_m;
    logic        mv;
    logic [15:0] busy_m;
    int          tests;
    int          fails;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // {gt,lt,eq,unord}
    function automatic logic [3:0] ref_cls(input logic [31:0] x);
        if (x[30:0] == 31'd0) return 4'b0010;
        if (x[30:23] == 8'hFF && x[22:0] != 23'd0) return 4'b0001;
        return x[31] ? 4'b0100 : 4'b1000;
    endfunction

    function automatic logic [3:0] exp_grant(input logic [3:0] v, input logic [1:0] p);
        for (int k = 0; k < NR; k++) begin
            int idx = (int'(p) + k) % NR;
            if (v[idx]) return 4'(1 << idx);
        end
        return 4'b0000;
    endfunction

    // One clock: drive after the falling edge, check before the rising edge, advance the model.
    task automatic cycle(input logic [3:0] v, input logic rdy);
        logic [3:0] g;
        logic [5:0] front;
        int         gi;
        req_valid = v;
        rsp_ready = rdy;
        req_data  = {data_m[3], data_m[2], data_m[1], data_m[0]};
        #1;
        g = (!mv || rdy) ? exp_grant(v, ptr_m) : 4'b0000;
        chk("req_ready", 32'(req_ready), 32'(g));
        chk("busy_cnt", 32'(busy_cnt), 32'(busy_m));
        chk("rsp_valid", 32'(rsp_valid), 32'(mv));
        if (mv) begin
            chk("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) begin
                front = sb_q[0];
                chk("rsp_id", 32'(rsp_id), 32'(front[5:4]));
                chk("rsp_flags", 32'({rsp_gt, rsp_lt, rsp_eq, rsp_unord}), 32'(front[3:0]));
                if (rdy) void'(sb_q.pop_front());
            end
        end
        if (mv && !rdy && busy_m != 16'hFFFF) busy_m = busy_m + 16'd1;
        if (g != 4'b0000) begin
            gi = 0;
            for (int i = 0; i < NR; i++) if (g[i]) gi = i;
            sb_q.push_back({2'(gi), ref_cls(data_m[gi])});
            ptr_m = 2'((gi + 1) % NR);
            mv    = 1'b1;
        end else if (rdy) begin
            mv = 1'b0;
        end
        @(negedge clk);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        ptr_m = '0;
        mv = 1'b0;
        busy_m = '0;
        for (int i = 0; i < NR; i++) data_m[i] = 32'h0;
        rst_n = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b0;
        req_data = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rsp_id", 32'(rsp_id), 32'd0);
        chk("reset_flags", 32'({rsp_gt, rsp_lt, rsp_eq, rsp_unord}), 32'd0);
        chk("reset_busy", 32'(busy_cnt), 32'd0);
        chk("reset_req_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single request: 4.0 on requester 0
        data_m[0] = 32'h40800000;
        cycle(4'b0001, 1'b1);
        cycle(4'b0000, 1'b1);

        // -0, NaN, denormal; then requester 3 again to bring the pointer back to 0
        data_m[2] = 32'h80000000;
        cycle(4'b0100, 1'b1);
        data_m[3] = 32'h7FC00000;
        cycle(4'b1000, 1'b1);
        data_m[1] = 32'h00000001;
        cycle(4'b0010, 1'b1);
        cycle(4'b1000, 1'b1);
        cycle(4'b0000, 1'b1);
        chk("ptr_at_zero_grant", 32'(exp_grant(4'b1111, ptr_m)), 32'b0001);

        // Round robin, full throughput
        data_m[0] = 32'h3F800000;
        data_m[1] = 32'hBF800000;
        data_m[2] = 32'h00000000;
        data_m[3] = 32'h7F800000;
        for (int n = 0; n < 8; n++) cycle(4'b1111, 1'b1);
        cycle(4'b0000, 1'b1);

        // Backpressure on -10.0
        data_m[0] = 32'hC1200000;
        cycle(4'b0001, 1'b1);
        for (int n = 0; n < 5; n++) cycle(4'b1111, 1'b0);
        chk("busy_after_stall", 32'(busy_cnt), 32'd5);
        chk("stall_rsp_lt", 32'(rsp_lt), 32'd1);
        cycle(4'b1111, 1'b1);
        cycle(4'b0000, 1'b1);
        cycle(4'b0000, 1'b1);

        // Saturation of the stall counter
        cycle(4'b0001, 1'b1);
        req_valid = '0;
        rsp_ready = 1'b0;
        repeat (70000) @(negedge clk);
        busy_m = (int'(busy_m) + 70000 > 65535) ? 16'hFFFF : 16'(int'(busy_m) + 70000);
        #1;
        chk("busy_saturated", 32'(busy_cnt), 32'h0000FFFF);
        chk("sat_rsp_valid", 32'(rsp_valid), 32'd1);
        @(negedge clk);
        cycle(4'b0000, 1'b0);

        // Asynchronous reset with a response pending
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("async_rst_busy", 32'(busy_cnt), 32'd0);
        sb_q.delete();
        mv = 1'b0;
        ptr_m = '0;
        busy_m = '0;
        @(negedge clk);
        rst_n = 1'b1;
        cycle(4'b1010, 1'b1);
        chk("post_rst_rsp_id", 32'(rsp_id), 32'd1);
        cycle(4'b0000, 1'b1);
        cycle(4'b0000, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
